jam: RTL and testbench



---
 rtl/jam_pkg.sv | 11 +
 rtl/jam_next_perm.sv | 33 +++
 rtl/jam.sv | 83 ++++++++
 tb/tb_jam.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared constants, types and FSM encoding for the 8x8 exhaustive assignment solver.
package jam_pkg;
  localparam int N  = 8;
  localparam int CW = 7;
  localparam int SW = 10;

  typedef logic [2:0] idx_t;
  typedef idx_t [N-1:0] perm_t;

  typedef enum logic [1:0] {READ, DRAIN, EVAL, DONE} state_t;
endpackage

// File: rtl/jam_next_perm.sv
// Lexicographic successor of an 8-element permutation; last_o flags the descending order.
module jam_next_perm
  import jam_pkg::*;
(
  input  perm_t p_i,
  output perm_t nxt_o,
  output logic  last_o
);
  int    piv, sj;
  logic  found;
  perm_t sw;

  always_comb begin
    found = 1'b0;
    piv   = 0;
    sj    = 0;
    for (int i = 0; i < N-1; i++)
      if (p_i[idx_t'(i)] < p_i[idx_t'(i+1)]) begin
        found = 1'b1;
        piv   = i;
      end
    for (int k = 0; k < N; k++)
      if (k > piv && p_i[idx_t'(k)] > p_i[idx_t'(piv)]) sj = k;
    sw = p_i;
    sw[idx_t'(piv)] = p_i[idx_t'(sj)];
    sw[idx_t'(sj)]  = p_i[idx_t'(piv)];
    // Suffix after the pivot is descending; reversing makes it the smallest tail.
    nxt_o = sw;
    for (int k = 0; k < N; k++)
      if (k > piv) nxt_o[idx_t'(k)] = sw[idx_t'(piv + N - k)];
    last_o = ~found;
  end
endmodule

// File: rtl/jam.sv
// Walks all 40320 assignments, 11 cycles each, against a 2-cycle-latency cost ROM.
module jam
  import jam_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  output logic [2:0]    W,
  output logic [2:0]    J,
  input  logic [CW-1:0] Cost,
  output logic [3:0]    MatchCount,
  output logic [8:0]    MinCost,
  output logic          Valid
);
  state_t        state_q;
  idx_t          cnt_q;
  perm_t         perm_q, perm_d;
  logic          last;
  logic [SW-1:0] sum_q, best_q;
  logic [3:0]    count_q, mc_q;
  logic [2:0]    w_q, j_q;
  logic [8:0]    min_q;
  logic          valid_q;

  jam_next_perm u_np (.p_i(perm_q), .nxt_o(perm_d), .last_o(last));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= READ;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) perm_q[i] <= idx_t'(i);
      sum_q   <= '0;
      best_q  <= '1;
      count_q <= '0;
      w_q     <= '0;
      j_q     <= '0;
      min_q   <= '0;
      mc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // Cost for the address issued two edges ago arrives now.
      if ((state_q == READ && cnt_q >= 3'd2) || state_q == DRAIN)
        sum_q <= sum_q + SW'(Cost);
      case (state_q)
        READ: begin
          w_q   <= cnt_q;
          j_q   <= perm_q[cnt_q];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= DRAIN;
        end
        DRAIN: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_q   <= '0;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          sum_q <= '0;
          if (sum_q < best_q) begin
            best_q  <= sum_q;
            count_q <= 4'd1;
          end else if (sum_q == best_q && count_q != 4'd15) begin
            count_q <= count_q + 4'd1;
          end
          perm_q  <= perm_d;
          state_q <= last ? DONE : READ;
        end
        DONE: begin
          valid_q <= 1'b1;
          min_q   <= best_q[8:0];
          mc_q    <= count_q;
        end
        default: state_q <= READ;
      endcase
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign MinCost    = min_q;
  assign MatchCount = mc_q;
  assign Valid      = valid_q;
endmodule

// File: tb/tb_jam.sv
// Bench for jam: cost-pattern table, random tables against a subset-DP model, mid-run reset.
module tb_jam;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic [3:0] MatchCount;
  logic [8:0] MinCost;
  logic       Valid;

  int cost [8][8];
  logic [6:0] rom_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int pat;
    int exp_min;
    int exp_cnt;
  } vec_t;
  vec_t vecs [5];

  jam dut (
    .CLK(CLK), .RST(RST), .W(W), .J(J), .Cost(Cost),
    .MatchCount(MatchCount), .MinCost(MinCost), .Valid(Valid)
  );

  always #5 CLK = ~CLK;

  // External ROM: one registered read stage.
  always @(posedge CLK) rom_q <= 7'(cost[W][J]);
  assign Cost = rom_q;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        case (pat)
          0:       cost[w][j] = 0;
          1:       cost[w][j] = (j == w) ? 0 : 100;
          2:       cost[w][j] = w + j;
          3:       cost[w][j] = (j == 7 - w) ? 1 : 50;
          default: cost[w][j] = int'($urandom_range(0, 100));
        endcase
  endtask

  // Minimum and tie count over all assignments via DP on the set of used jobs.
  task automatic model(output int mn, output int ct);
    int     dmin [256];
    longint dcnt [256];
    logic [7:0] m;
    int w, nm, c;
    for (int i = 0; i < 256; i++) begin dmin[i] = 1 << 30; dcnt[i] = 0; end
    dmin[0] = 0; dcnt[0] = 1;
    for (int s = 0; s < 256; s++) begin
      m = 8'(s);
      w = $countones(m);
      if (w < 8 && dcnt[s] != 0)
        for (int j = 0; j < 8; j++)
          if (!m[j]) begin
            nm = s | (1 << j);
            c  = dmin[s] + cost[w][j];
            if (c < dmin[nm]) begin dmin[nm] = c; dcnt[nm] = dcnt[s]; end
            else if (c == dmin[nm]) dcnt[nm] += dcnt[s];
          end
    end
    mn = dmin[255];
    ct = (dcnt[255] > 15) ? 15 : int'(dcnt[255]);
  endtask

  task automatic do_reset();
    @(negedge CLK) RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_W", int'(W), 0);
    chk("rst_J", int'(J), 0);
    chk("rst_MinCost", int'(MinCost), 0);
    chk("rst_MatchCount", int'(MatchCount), 0);
    chk("rst_Valid", int'(Valid), 0);
    RST = 1'b0;
  endtask

  // First permutation is the identity, the second swaps the last two jobs.
  task automatic check_addr_seq();
    int p2 [8] = '{0, 1, 2, 3, 4, 5, 7, 6};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("p1_W%0d", i), int'(W), i);
      chk($sformatf("p1_J%0d", i), int'(J), i);
    end
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("p2_W%0d", i), int'(W), i);
      chk($sformatf("p2_J%0d", i), int'(J), p2[i]);
    end
  endtask

  task automatic run_and_check(input string tag, input int exp_min, input int exp_cnt);
    int cyc = 0;
    int hmin, hcnt;
    while (!Valid && cyc < 600000) begin
      @(negedge CLK);
      cyc++;
      if (!Valid && (cyc % 65536) == 0) begin
        chk({tag, "_early_MinCost"}, int'(MinCost), 0);
        chk({tag, "_early_MatchCount"}, int'(MatchCount), 0);
      end
    end
    chk({tag, "_Valid"}, int'(Valid), 1);
    chk({tag, "_MinCost"}, int'(MinCost), exp_min);
    chk({tag, "_MatchCount"}, int'(MatchCount), exp_cnt);
    hmin = int'(MinCost);
    hcnt = int'(MatchCount);
    repeat (20) @(negedge CLK);
    chk({tag, "_hold_Valid"}, int'(Valid), 1);
    chk({tag, "_hold_MinCost"}, int'(MinCost), hmin);
    chk({tag, "_hold_MatchCount"}, int'(MatchCount), hcnt);
  endtask

  initial begin
    int mn, ct;
    vecs[0] = '{pat: 0, exp_min: 0,  exp_cnt: 15};
    vecs[1] = '{pat: 1, exp_min: 0,  exp_cnt: 1};
    vecs[2] = '{pat: 2, exp_min: 56, exp_cnt: 15};
    vecs[3] = '{pat: 3, exp_min: 8,  exp_cnt: 1};
    vecs[4] = '{pat: 4, exp_min: -1, exp_cnt: -1};

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].pat);
      if (vecs[v].exp_min < 0) begin
        model(mn, ct);
        vecs[v].exp_min = mn;
        vecs[v].exp_cnt = ct;
      end
      do_reset();
      if (v == 0) check_addr_seq();
      run_and_check($sformatf("pat%0d", vecs[v].pat), vecs[v].exp_min, vecs[v].exp_cnt);
    end

    // Abort mid-run, then a full rerun must still give the model's answer.
    fill(4);
    model(mn, ct);
    do_reset();
    repeat (100000) @(negedge CLK);
    chk("midrun_Valid_low", int'(Valid), 0);
    do_reset();
    check_addr_seq();
    run_and_check("rerun", mn, ct);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
